main_control: RTL and testbench

MAIN_CONTROL -- requirements
Module: main_control

---
 rtl/cpu_pkg.sv | 61 ++++++
 rtl/main_control_if.sv | 39 +++
 rtl/ctrl_decode.sv | 27 ++
 rtl/main_control.sv | 168 ++++++++++++++++
 tb/tb_main_control.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path.
// Holds the state encoding, opcode values, instruction classes, the
// xALU / alu_src_b / pc_src select encodings and the common field widths.
package cpu_pkg;

    localparam int unsigned OPCODE_W  = 6;
    localparam int unsigned RETIRED_W = 16;

    // Controller states; legacy-compatible plain constants.
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_FETCH  = 3'd1;
    localparam state_t S_DECODE = 3'd2;
    localparam state_t S_EXEC   = 3'd3;
    localparam state_t S_MEM    = 3'd4;
    localparam state_t S_WB     = 3'd5;
    localparam state_t S_HALT   = 3'd6;

    // Opcode values (instruction[31:26]).
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'd1;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'd2;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'd3;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'd4;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'd5;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'd6;
    localparam logic [OPCODE_W-1:0] OP_HALT  = 6'd7;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_ADDI,
        CLS_ANDI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_J,
        CLS_HALT
    } insn_class_t;

    typedef struct packed {
        insn_class_t cls;
        logic        legal;
    } decode_t;

    // xALU: operation class handed to the ALU control decoder.
    localparam logic [2:0] XALU_ADD    = 3'b000;
    localparam logic [2:0] XALU_RTYPE  = 3'b001;
    localparam logic [2:0] XALU_BRANCH = 3'b010;
    localparam logic [2:0] XALU_LOGIC  = 3'b011;

    // alu_src_b: ALU B operand select.
    localparam logic [1:0] ASB_REG  = 2'b00;
    localparam logic [1:0] ASB_FOUR = 2'b01;
    localparam logic [1:0] ASB_IMM  = 2'b10;

    // pc_src: next-PC select.
    localparam logic [1:0] PCS_SEQ    = 2'b00;
    localparam logic [1:0] PCS_BRANCH = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/main_control_if.sv
// Control bundle between main_control and the datapath / memory.
// master: the controller (samples run/opcode/zero/mem_ready, drives strobes,
//         selects, illegal, halted and retired).
// slave : the datapath side, directions mirrored.
interface main_control_if;
    import cpu_pkg::*;

    logic                 run;
    logic [OPCODE_W-1:0]  opcode;
    logic                 zero;
    logic                 mem_ready;

    logic [2:0]           xALU;
    logic [1:0]           alu_src_b;
    logic [1:0]           pc_src;
    logic                 ir_we;
    logic                 pc_we;
    logic                 reg_we;
    logic                 mem_req;
    logic                 mem_we;
    logic                 mem_to_reg;
    logic                 reg_dst;
    logic                 illegal;
    logic                 halted;
    logic [RETIRED_W-1:0] retired;

    modport master (
        input  run, opcode, zero, mem_ready,
        output xALU, alu_src_b, pc_src, ir_we, pc_we, reg_we, mem_req, mem_we,
               mem_to_reg, reg_dst, illegal, halted, retired
    );

    modport slave (
        output run, opcode, zero, mem_ready,
        input  xALU, alu_src_b, pc_src, ir_we, pc_we, reg_we, mem_req, mem_we,
               mem_to_reg, reg_dst, illegal, halted, retired
    );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder.
// opcode : instruction[31:26]
// dec    : instruction class plus legality flag (opcodes 0..7 are legal)
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output decode_t             dec
);

    always_comb begin
        dec.legal = 1'b1;
        dec.cls   = CLS_RTYPE;
        case (opcode)
            OP_RTYPE: dec.cls = CLS_RTYPE;
            OP_ADDI:  dec.cls = CLS_ADDI;
            OP_ANDI:  dec.cls = CLS_ANDI;
            OP_LW:    dec.cls = CLS_LW;
            OP_SW:    dec.cls = CLS_SW;
            OP_BEQ:   dec.cls = CLS_BEQ;
            OP_J:     dec.cls = CLS_J;
            OP_HALT:  dec.cls = CLS_HALT;
            default:  dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/main_control.sv
// Multi-cycle CPU main controller: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT FSM
// plus a retired-instruction counter.
// clk, rst_n : clock and asynchronous active-low reset
// bus        : main_control_if.master (run/opcode/zero/mem_ready in; datapath
//              strobes, selects, illegal, halted and retired out)
module main_control
    import cpu_pkg::*;
#(
    // Reset value of retired; leave at zero in normal use.
    parameter logic [RETIRED_W-1:0] RETIRED_INIT = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    main_control_if.master bus
);

    state_t               state_q, state_d;
    decode_t              dec, dec_q;
    logic [RETIRED_W-1:0] retired_q;
    state_t               next_insn;
    logic                 retire;

    logic [2:0] xalu;
    logic [1:0] alu_src_b, pc_src;
    logic       ir_we, pc_we, reg_we, mem_req, mem_we, mem_to_reg, reg_dst;
    logic       illegal, halted;

    ctrl_decode u_decode (
        .opcode (bus.opcode),
        .dec    (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            dec_q     <= '{cls: CLS_RTYPE, legal: 1'b0};
            retired_q <= RETIRED_INIT;
        end else begin
            state_q <= state_d;
            // Opcode is only meaningful while the instruction register loads.
            if (ir_we) begin
                dec_q <= dec;
            end
            if (retire) begin
                retired_q <= retired_q + 1'b1;
            end
        end
    end

    // run is only consulted at instruction boundaries.
    assign next_insn = bus.run ? S_FETCH : S_IDLE;

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        xalu       = XALU_ADD;
        alu_src_b  = ASB_REG;
        pc_src     = PCS_SEQ;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = ASB_FOUR;
                if (bus.mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!dec_q.legal) begin
                    illegal = 1'b1;
                    state_d = next_insn;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (dec_q.cls)
                    CLS_RTYPE: begin
                        xalu    = XALU_RTYPE;
                        state_d = S_WB;
                    end
                    CLS_ADDI: begin
                        alu_src_b = ASB_IMM;
                        state_d   = S_WB;
                    end
                    CLS_ANDI: begin
                        xalu      = XALU_LOGIC;
                        alu_src_b = ASB_IMM;
                        state_d   = S_WB;
                    end
                    CLS_LW, CLS_SW: begin
                        alu_src_b = ASB_IMM;
                        state_d   = S_MEM;
                    end
                    CLS_BEQ: begin
                        xalu    = XALU_BRANCH;
                        pc_src  = PCS_BRANCH;
                        pc_we   = bus.zero;
                        retire  = 1'b1;
                        state_d = next_insn;
                    end
                    CLS_J: begin
                        pc_src  = PCS_JUMP;
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = next_insn;
                    end
                    CLS_HALT: begin
                        state_d = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (dec_q.cls == CLS_SW);
                if (bus.mem_ready) begin
                    if (dec_q.cls == CLS_SW) begin
                        retire  = 1'b1;
                        state_d = next_insn;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                reg_dst    = (dec_q.cls == CLS_RTYPE);
                mem_to_reg = (dec_q.cls == CLS_LW);
                retire     = 1'b1;
                state_d    = next_insn;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.xALU       = xalu;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.pc_src     = pc_src;
    assign bus.ir_we      = ir_we;
    assign bus.pc_we      = pc_we;
    assign bus.reg_we     = reg_we;
    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_dst    = reg_dst;
    assign bus.illegal    = illegal;
    assign bus.halted     = halted;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_main_control.sv
// Self-checking bench for main_control: randomized instruction stream against
// a per-instruction phase model, plus directed reset, halt and wrap cases.
module tb_main_control;
    import cpu_pkg::*;

    typedef struct packed {
        logic [2:0] xalu;
        logic [1:0] asb;
        logic [1:0] pcs;
        logic       ir_we;
        logic       pc_we;
        logic       reg_we;
        logic       mem_req;
        logic       mem_we;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       illegal;
        logic       halted;
    } outs_t;

    logic clk;
    logic rst_n;
    logic rst_w_n;

    main_control_if bus ();
    main_control_if bus_w ();

    main_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    main_control #(
        .RETIRED_INIT (16'hFFFD)
    ) dut_wrap (
        .clk   (clk),
        .rst_n (rst_w_n),
        .bus   (bus_w)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_retired = '0;
    logic        model_idle = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not complete");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] ro();
        return 6'($urandom);
    endfunction

    function automatic outs_t observe();
        outs_t o;
        o.xalu       = bus.xALU;
        o.asb        = bus.alu_src_b;
        o.pcs        = bus.pc_src;
        o.ir_we      = bus.ir_we;
        o.pc_we      = bus.pc_we;
        o.reg_we     = bus.reg_we;
        o.mem_req    = bus.mem_req;
        o.mem_we     = bus.mem_we;
        o.mem_to_reg = bus.mem_to_reg;
        o.reg_dst    = bus.reg_dst;
        o.illegal    = bus.illegal;
        o.halted     = bus.halted;
        return o;
    endfunction

    // Expected outputs per instruction phase.
    function automatic outs_t e_fetch(input logic rdy);
        outs_t o = '0;
        o.mem_req = 1'b1;
        o.asb     = 2'b01;
        o.ir_we   = rdy;
        o.pc_we   = rdy;
        return o;
    endfunction

    function automatic outs_t e_decode(input logic legal);
        outs_t o = '0;
        o.illegal = !legal;
        return o;
    endfunction

    function automatic outs_t e_exec(input logic [5:0] op, input logic z);
        outs_t o = '0;
        case (op)
            6'd0: o.xalu = 3'b001;
            6'd1, 6'd3, 6'd4: o.asb = 2'b10;
            6'd2: begin o.xalu = 3'b011; o.asb = 2'b10; end
            6'd5: begin o.xalu = 3'b010; o.pcs = 2'b01; o.pc_we = z; end
            6'd6: begin o.pcs = 2'b10; o.pc_we = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic outs_t e_mem(input logic [5:0] op);
        outs_t o = '0;
        o.mem_req = 1'b1;
        o.mem_we  = (op == 6'd4);
        return o;
    endfunction

    function automatic outs_t e_wb(input logic [5:0] op);
        outs_t o = '0;
        o.reg_we     = 1'b1;
        o.reg_dst    = (op == 6'd0);
        o.mem_to_reg = (op == 6'd3);
        return o;
    endfunction

    function automatic outs_t e_halt();
        outs_t o = '0;
        o.halted = 1'b1;
        return o;
    endfunction

    // One clock cycle: entered at posedge+1, drives inputs, compares mid-cycle.
    task automatic step(input logic r, input logic [5:0] op, input logic z, input logic mr,
                        input outs_t e, input string tag);
        bus.run       = r;
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = mr;
        #3;
        check_eq({tag, ".outs"}, 32'(observe()), 32'(e));
        check_eq({tag, ".retired"}, 32'(bus.retired), 32'(model_retired));
        @(posedge clk);
        #1;
    endtask

    task automatic finish_insn(input logic run_after);
        model_retired = model_retired + 16'd1;
        model_idle    = !run_after;
    endtask

    // Runs one instruction through its phases; fw/mw are memory wait cycles.
    task automatic run_insn(input logic [5:0] op, input int fw, input int mw, input logic zx,
                            input logic run_after);
        bit legal = (op < 6'd8);
        if (model_idle) begin
            repeat ($urandom_range(0, 1)) step(1'b0, ro(), rb(), rb(), '0, "idle");
            step(1'b1, ro(), rb(), rb(), '0, "idle_go");
            model_idle = 1'b0;
        end
        for (int i = 0; i < fw; i++) step(rb(), ro(), rb(), 1'b0, e_fetch(1'b0), "fetch_wait");
        step(rb(), op, rb(), 1'b1, e_fetch(1'b1), "fetch");
        if (!legal) begin
            step(run_after, ro(), rb(), rb(), e_decode(1'b0), "decode_illegal");
            model_idle = !run_after;
            return;
        end
        step(rb(), ro(), rb(), rb(), e_decode(1'b1), "decode");
        if (op == OP_BEQ || op == OP_J) begin
            step(run_after, ro(), zx, rb(), e_exec(op, zx), "exec_br");
            finish_insn(run_after);
            return;
        end
        step(rb(), ro(), zx, rb(), e_exec(op, zx), "exec");
        if (op == OP_HALT) return;
        if (op == OP_LW || op == OP_SW) begin
            for (int i = 0; i < mw; i++) step(rb(), ro(), rb(), 1'b0, e_mem(op), "mem_wait");
            if (op == OP_SW) begin
                step(run_after, ro(), rb(), 1'b1, e_mem(op), "mem_sw");
                finish_insn(run_after);
                return;
            end
            step(rb(), ro(), rb(), 1'b1, e_mem(op), "mem_lw");
        end
        step(run_after, ro(), rb(), rb(), e_wb(op), "wb");
        finish_insn(run_after);
    endtask

    initial begin
        logic [5:0]  op;
        logic [15:0] exp_w;
        int          sel;

        rst_n           = 1'b0;
        rst_w_n         = 1'b0;
        bus.run         = 1'b1;
        bus.opcode      = '0;
        bus.zero        = 1'b0;
        bus.mem_ready   = 1'b1;
        bus_w.run       = 1'b1;
        bus_w.opcode    = OP_RTYPE;
        bus_w.zero      = 1'b0;
        bus_w.mem_ready = 1'b1;
        #2;
        check_eq("reset.outs", 32'(observe()), 32'd0);
        check_eq("reset.retired", 32'(bus.retired), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed: R-type back to back with immediate mem_ready.
        run_insn(OP_RTYPE, 0, 0, 1'b0, 1'b1);
        // LW with three wait cycles in both fetch and memory.
        run_insn(OP_LW, 3, 3, 1'b0, 1'b1);
        // BEQ taken then not taken.
        run_insn(OP_BEQ, 0, 0, 1'b1, 1'b1);
        run_insn(OP_BEQ, 0, 0, 1'b0, 1'b1);
        // Undefined opcode.
        run_insn(6'd45, 0, 0, 1'b0, 1'b1);
        // run dropped at a boundary, then resumed.
        run_insn(OP_J, 1, 0, 1'b0, 1'b0);
        run_insn(OP_SW, 0, 2, 1'b0, 1'b1);

        // Randomized instruction stream.
        for (int n = 0; n < 150; n++) begin
            sel = int'($urandom_range(0, 9));
            op  = (sel < 7) ? 6'(sel) : 6'(8 + $urandom_range(0, 55));
            run_insn(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rb(),
                     ($urandom_range(0, 3) != 0));
        end

        // Reset in the middle of an SW memory wait.
        run_insn(OP_RTYPE, 0, 0, 1'b0, 1'b1);
        step(rb(), OP_SW, rb(), 1'b1, e_fetch(1'b1), "sw_fetch");
        step(rb(), ro(), rb(), rb(), e_decode(1'b1), "sw_decode");
        step(rb(), ro(), rb(), rb(), e_exec(OP_SW, 1'b0), "sw_exec");
        step(1'b1, ro(), rb(), 1'b0, e_mem(OP_SW), "sw_mem_wait");
        bus.mem_ready = 1'b0;
        #1;
        check_eq("sw_mem.pre_reset", 32'({bus.mem_req, bus.mem_we}), 32'b11);
        rst_n = 1'b0;
        #1;
        check_eq("sw_mem.reset_req", 32'({bus.mem_req, bus.mem_we}), 32'b00);
        check_eq("sw_mem.reset_outs", 32'(observe()), 32'd0);
        check_eq("sw_mem.reset_retired", 32'(bus.retired), 32'd0);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        model_retired = '0;
        model_idle    = 1'b1;

        // HALT is absorbing until reset.
        run_insn(OP_ADDI, 0, 0, 1'b0, 1'b1);
        run_insn(OP_HALT, 1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) step(rb(), ro(), rb(), rb(), e_halt(), "halted");
        rst_n = 1'b0;
        #1;
        check_eq("halt.reset_outs", 32'(observe()), 32'd0);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        model_retired = '0;
        model_idle    = 1'b1;
        run_insn(OP_ANDI, 0, 0, 1'b0, 1'b1);

        // Counter wrap: preloaded instance retires one R-type every 4 cycles.
        rst_w_n = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            #3;
            exp_w = 16'hFFFD + 16'((c >= 1) ? (c - 1) / 4 : 0);
            check_eq("wrap.retired", 32'(bus_w.retired), 32'(exp_w));
            if (c > 0 && c % 4 == 0)
                check_eq("wrap.wb", 32'({bus_w.reg_we, bus_w.reg_dst}), 32'b11);
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
